// File: rtl/llc_snoop_responder_pkg.sv
// Shared types and constants for the LLC snoop responder: bus ops, snoop results,
// L1 message codes, responder FSM states and the MESI state encoding.
package llc_snoop_responder_pkg;

  localparam int unsigned STATE_WIDTH = 2;

  typedef enum logic [2:0] {
    READ       = 3'd1,
    WRITE      = 3'd2,
    INVALIDATE = 3'd3,
    RWIM       = 3'd4
  } busopt_t;

  typedef enum logic [2:0] {
    NOHIT = 3'd0,
    HIT   = 3'd1,
    HITM  = 3'd2
  } snoop_result_t;

  typedef enum logic [2:0] {
    GETLINE = 3'd1,
    SENDLINE,
    INVALIDATELINE,
    EVICTLINE
  } l1_msg_t;

  typedef enum logic [2:0] {
    IDLE,
    LOOKUP,
    GETL,
    INVL,
    UPDATE,
    RESPOND
  } snp_fsm_t;

  localparam logic [STATE_WIDTH-1:0] MESI_M = 2'd0;
  localparam logic [STATE_WIDTH-1:0] MESI_E = 2'd1;
  localparam logic [STATE_WIDTH-1:0] MESI_S = 2'd2;
  localparam logic [STATE_WIDTH-1:0] MESI_I = 2'd3;

endpackage

// File: rtl/snoop_mesi_decode.sv
// Combinational MESI snoop decode: maps a snooped op and the looked-up line state to
// the snoop result, required L1 messages, the new MESI state and protocol errors.
module snoop_mesi_decode
  import llc_snoop_responder_pkg::*;
(
  input  logic [2:0]             op,
  input  logic                   hit,
  input  logic [STATE_WIDTH-1:0] state,
  output snoop_result_t          result,
  output logic                   need_getline,
  output logic                   need_inval,
  output logic [STATE_WIDTH-1:0] next_state,
  output logic                   err
);

  // A tag match on an Invalid line is treated exactly like a miss.
  logic valid_hit;
  assign valid_hit = hit && (state != MESI_I);

  always_comb begin
    result       = NOHIT;
    need_getline = 1'b0;
    need_inval   = 1'b0;
    next_state   = state;
    err          = 1'b0;
    case (op)
      READ: begin
        if (valid_hit) begin
          next_state = MESI_S;
          if (state == MESI_M) begin
            result       = HITM;
            need_getline = 1'b1;
          end else begin
            result = HIT;
          end
        end
      end
      RWIM: begin
        if (valid_hit) begin
          next_state = MESI_I;
          need_inval = 1'b1;
          if (state == MESI_M) begin
            result       = HITM;
            need_getline = 1'b1;
          end else begin
            result = HIT;
          end
        end
      end
      INVALIDATE: begin
        if (valid_hit) begin
          if (state == MESI_S) begin
            result     = HIT;
            need_inval = 1'b1;
            next_state = MESI_I;
          end else begin
            err = 1'b1;
          end
        end
      end
      WRITE: begin
        if (valid_hit) begin
          err = 1'b1;
        end
      end
      default: begin
        err = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/llc_snoop_responder.sv
// Snoop responder: looks up the LLC tag/MESI array for one snooped bus op, issues any
// L1 messages, writes the new MESI state and returns NOHIT/HIT/HITM to the bus.
module llc_snoop_responder
  import llc_snoop_responder_pkg::*;
#(
  parameter int unsigned ADDR_SIZE  = 32,
  parameter int unsigned BYTE_BITS  = 6,
  parameter int unsigned INDEX_BITS = 15,
  parameter int unsigned TAG_BITS   = 11,
  parameter int unsigned ASSOC_BITS = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   snp_valid,
  output logic                   snp_ready,
  input  logic [2:0]             snp_op,
  input  logic [ADDR_SIZE-1:0]   snp_addr,
  output logic                   lkp_req,
  output logic [INDEX_BITS-1:0]  lkp_index,
  output logic [TAG_BITS-1:0]    lkp_tag,
  input  logic                   lkp_ack,
  input  logic                   lkp_hit,
  input  logic [ASSOC_BITS-1:0]  lkp_way,
  input  logic [STATE_WIDTH-1:0] lkp_state,
  output logic                   upd_en,
  output logic [INDEX_BITS-1:0]  upd_index,
  output logic [ASSOC_BITS-1:0]  upd_way,
  output logic [STATE_WIDTH-1:0] upd_state,
  output logic                   l1_msg_valid,
  output logic [2:0]             l1_msg,
  output logic [ADDR_SIZE-1:0]   l1_msg_addr,
  input  logic                   l1_msg_ready,
  output logic                   rsp_valid,
  output logic [2:0]             rsp_result,
  input  logic                   rsp_ready,
  output logic                   proto_err
);

  localparam int unsigned LineBits = ADDR_SIZE - BYTE_BITS;

  snp_fsm_t                fsm_q, fsm_d;
  logic [2:0]              op_q;
  logic [LineBits-1:0]     line_q;
  logic                    hit_q;
  logic [ASSOC_BITS-1:0]   way_q;
  logic [STATE_WIDTH-1:0]  mesi_q;

  logic                    accept;
  logic                    dec_hit;
  logic [STATE_WIDTH-1:0]  dec_state;
  snoop_result_t           dec_result;
  logic                    dec_getline;
  logic                    dec_inval;
  logic [STATE_WIDTH-1:0]  dec_next;
  logic                    dec_err;
  logic [INDEX_BITS-1:0]   line_index;
  logic [ADDR_SIZE-1:0]    line_addr;

  // Only whole lines are tracked; the byte offset never matters here.
  logic unused_offset;
  assign unused_offset = ^snp_addr[BYTE_BITS-1:0];

  assign accept     = snp_valid && snp_ready;
  assign line_index = line_q[INDEX_BITS-1:0];
  assign line_addr  = {line_q, {BYTE_BITS{1'b0}}};

  // The LOOKUP exit needs the message decision in the ack cycle, so the decoder sees the
  // live lookup result there and the latched copy in every later state.
  assign dec_hit   = (fsm_q == LOOKUP) ? lkp_hit : hit_q;
  assign dec_state = (fsm_q == LOOKUP) ? lkp_state : mesi_q;

  snoop_mesi_decode u_decode (
    .op           (op_q),
    .hit          (dec_hit),
    .state        (dec_state),
    .result       (dec_result),
    .need_getline (dec_getline),
    .need_inval   (dec_inval),
    .next_state   (dec_next),
    .err          (dec_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      fsm_q  <= IDLE;
      op_q   <= '0;
      line_q <= '0;
      hit_q  <= 1'b0;
      way_q  <= '0;
      mesi_q <= '0;
    end else begin
      fsm_q <= fsm_d;
      if (accept) begin
        op_q   <= snp_op;
        line_q <= snp_addr[ADDR_SIZE-1:BYTE_BITS];
      end
      if ((fsm_q == LOOKUP) && lkp_ack) begin
        hit_q  <= lkp_hit;
        way_q  <= lkp_way;
        mesi_q <= lkp_state;
      end
    end
  end

  always_comb begin
    fsm_d        = fsm_q;
    snp_ready    = 1'b0;
    lkp_req      = 1'b0;
    lkp_index    = '0;
    lkp_tag      = '0;
    upd_en       = 1'b0;
    upd_index    = '0;
    upd_way      = '0;
    upd_state    = '0;
    l1_msg_valid = 1'b0;
    l1_msg       = '0;
    l1_msg_addr  = '0;
    rsp_valid    = 1'b0;
    rsp_result   = '0;
    proto_err    = 1'b0;
    // Outputs stay quiet for the whole reset cycle, whatever state the FSM was in.
    if (!rst) begin
      unique case (fsm_q)
        IDLE: begin
          snp_ready = 1'b1;
          if (snp_valid) begin
            fsm_d = LOOKUP;
          end
        end
        LOOKUP: begin
          lkp_req   = 1'b1;
          lkp_index = line_index;
          lkp_tag   = line_q[LineBits-1 -: TAG_BITS];
          if (lkp_ack) begin
            if (dec_getline) begin
              fsm_d = GETL;
            end else if (dec_inval) begin
              fsm_d = INVL;
            end else begin
              fsm_d = UPDATE;
            end
          end
        end
        GETL: begin
          l1_msg_valid = 1'b1;
          l1_msg       = GETLINE;
          l1_msg_addr  = line_addr;
          if (l1_msg_ready) begin
            fsm_d = dec_inval ? INVL : UPDATE;
          end
        end
        INVL: begin
          l1_msg_valid = 1'b1;
          l1_msg       = INVALIDATELINE;
          l1_msg_addr  = line_addr;
          if (l1_msg_ready) begin
            fsm_d = UPDATE;
          end
        end
        UPDATE: begin
          // Misses and error cases decode to an unchanged state, so no write is issued.
          if (dec_next != mesi_q) begin
            upd_en    = 1'b1;
            upd_index = line_index;
            upd_way   = way_q;
            upd_state = dec_next;
          end
          proto_err = dec_err;
          fsm_d     = RESPOND;
        end
        RESPOND: begin
          rsp_valid  = 1'b1;
          rsp_result = dec_result;
          if (rsp_ready) begin
            fsm_d = IDLE;
          end
        end
        default: begin
          fsm_d = IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_llc_snoop_responder.sv
// Self-checking bench for llc_snoop_responder: directed MESI cases, stalls, reset abort
// and randomized snoops checked against a table-level reference model.
module tb_llc_snoop_responder;
  import llc_snoop_responder_pkg::*;

  localparam int unsigned AW = 32;
  localparam int unsigned BB = 6;
  localparam int unsigned IB = 15;
  localparam int unsigned TB = 11;
  localparam int unsigned WB = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          snp_valid;
  logic          snp_ready;
  logic [2:0]    snp_op;
  logic [AW-1:0] snp_addr;
  logic          lkp_req;
  logic [IB-1:0] lkp_index;
  logic [TB-1:0] lkp_tag;
  logic          lkp_ack;
  logic          lkp_hit;
  logic [WB-1:0] lkp_way;
  logic [1:0]    lkp_state;
  logic          upd_en;
  logic [IB-1:0] upd_index;
  logic [WB-1:0] upd_way;
  logic [1:0]    upd_state;
  logic          l1_msg_valid;
  logic [2:0]    l1_msg;
  logic [AW-1:0] l1_msg_addr;
  logic          l1_msg_ready;
  logic          rsp_valid;
  logic [2:0]    rsp_result;
  logic          rsp_ready;
  logic          proto_err;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  llc_snoop_responder #(
    .ADDR_SIZE  (AW),
    .BYTE_BITS  (BB),
    .INDEX_BITS (IB),
    .TAG_BITS   (TB),
    .ASSOC_BITS (WB)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .snp_valid    (snp_valid),
    .snp_ready    (snp_ready),
    .snp_op       (snp_op),
    .snp_addr     (snp_addr),
    .lkp_req      (lkp_req),
    .lkp_index    (lkp_index),
    .lkp_tag      (lkp_tag),
    .lkp_ack      (lkp_ack),
    .lkp_hit      (lkp_hit),
    .lkp_way      (lkp_way),
    .lkp_state    (lkp_state),
    .upd_en       (upd_en),
    .upd_index    (upd_index),
    .upd_way      (upd_way),
    .upd_state    (upd_state),
    .l1_msg_valid (l1_msg_valid),
    .l1_msg       (l1_msg),
    .l1_msg_addr  (l1_msg_addr),
    .l1_msg_ready (l1_msg_ready),
    .rsp_valid    (rsp_valid),
    .rsp_result   (rsp_result),
    .rsp_ready    (rsp_ready),
    .proto_err    (proto_err)
  );

  // Every output except snp_ready, for the all-quiet checks.
  logic [88:0] side_outs;
  assign side_outs = {lkp_req, lkp_index, lkp_tag, upd_en, upd_index, upd_way, upd_state,
                      l1_msg_valid, l1_msg, l1_msg_addr, rsp_valid, rsp_result, proto_err};

  // Observations of the last snoop driven by do_snoop.
  int            obs_lat;
  int            obs_timeout;
  logic [IB-1:0] obs_idx;
  logic [TB-1:0] obs_tag;
  logic [2:0]    obs_msgs[$];
  int            obs_addr_bad;
  int            obs_upd_cnt;
  logic [IB-1:0] obs_upd_idx;
  logic [WB-1:0] obs_upd_way;
  logic [1:0]    obs_upd_state;
  int            obs_err_cnt;
  logic [2:0]    obs_res;
  int            obs_unstable;
  int            obs_ready_busy;
  int            obs_idle_after;

  // Reference: the snoop table evaluated on the effective line state (miss == Invalid).
  function automatic void ref_model(input logic [2:0] op, input logic hit, input logic [1:0] st,
                                    output logic [2:0] res, output int nmsg,
                                    output logic [2:0] m0, output logic [1:0] nxt,
                                    output bit err);
    logic [1:0] es;
    bit getl, inv;
    es   = hit ? st : MESI_I;
    res  = NOHIT;
    nxt  = es;
    err  = 1'b0;
    getl = 1'b0;
    inv  = 1'b0;
    if (op == READ) begin
      res  = (es == MESI_I) ? NOHIT : ((es == MESI_M) ? HITM : HIT);
      getl = (es == MESI_M);
      nxt  = (es == MESI_I) ? MESI_I : MESI_S;
    end else if (op == RWIM) begin
      res  = (es == MESI_I) ? NOHIT : ((es == MESI_M) ? HITM : HIT);
      getl = (es == MESI_M);
      inv  = (es != MESI_I);
      nxt  = MESI_I;
    end else if (op == INVALIDATE) begin
      if (es == MESI_S) begin
        res = HIT;
        inv = 1'b1;
        nxt = MESI_I;
      end else begin
        err = (es != MESI_I);
      end
    end else if (op == WRITE) begin
      err = (es != MESI_I);
    end else begin
      err = 1'b1;
    end
    nmsg = int'(getl) + int'(inv);
    m0   = getl ? GETLINE : INVALIDATELINE;
  endfunction

  // Drives one snoop with the given lookup answer and stall lengths, recording what it sees.
  task automatic do_snoop(input logic [2:0] op, input logic [AW-1:0] addr, input logic hit,
                          input logic [WB-1:0] way, input logic [1:0] st, input int ack_dly,
                          input int l1_dly, input int rsp_dly, input bit hold_valid);
    int n, lkp_cyc, msg_wait, rsp_wait, guard;
    bit done, msg_hold, rsp_hold;
    logic [2:0]    prev_msg;
    logic [AW-1:0] prev_addr;
    logic [AW-1:0] line;
    line = {addr[AW-1:BB], {BB{1'b0}}};
    obs_lat = -1; obs_timeout = 0; obs_idx = '0; obs_tag = '0; obs_msgs.delete();
    obs_addr_bad = 0; obs_upd_cnt = 0; obs_upd_idx = '0; obs_upd_way = '0; obs_upd_state = '0;
    obs_err_cnt = 0; obs_res = 3'd7; obs_unstable = 0; obs_ready_busy = 0; obs_idle_after = 0;
    prev_msg = '0; prev_addr = '0;
    @(negedge clk);
    snp_valid = 1'b1; snp_op = op; snp_addr = addr;
    guard = 0;
    while (!snp_ready && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    if (!snp_ready) begin
      obs_timeout = 1;
      snp_valid = 1'b0;
      return;
    end
    n = 0; lkp_cyc = 0; msg_wait = 0; rsp_wait = 0;
    done = 1'b0; msg_hold = 1'b0; rsp_hold = 1'b0;
    while (!done) begin
      @(negedge clk);
      n++;
      if (n > 300) begin
        obs_timeout = 1;
        break;
      end
      if (snp_ready) obs_ready_busy++;
      if (lkp_req) begin
        lkp_cyc++;
        if (lkp_cyc == 1) begin
          obs_idx = lkp_index;
          obs_tag = lkp_tag;
        end else if (lkp_index !== obs_idx || lkp_tag !== obs_tag) begin
          obs_unstable++;
        end
        lkp_ack = (lkp_cyc > ack_dly);
      end else begin
        lkp_ack = 1'b0;
      end
      lkp_hit   = lkp_ack ? hit : 1'($urandom);
      lkp_way   = lkp_ack ? way : WB'($urandom);
      lkp_state = lkp_ack ? st : 2'($urandom);
      if (l1_msg_valid) begin
        if (msg_hold && (l1_msg !== prev_msg || l1_msg_addr !== prev_addr)) obs_unstable++;
        if (l1_msg_addr !== line) obs_addr_bad++;
        msg_wait++;
        l1_msg_ready = (msg_wait > l1_dly);
        if (l1_msg_ready) begin
          obs_msgs.push_back(l1_msg);
          msg_hold = 1'b0;
          msg_wait = 0;
        end else begin
          msg_hold  = 1'b1;
          prev_msg  = l1_msg;
          prev_addr = l1_msg_addr;
        end
      end else begin
        l1_msg_ready = 1'b0;
        msg_hold = 1'b0;
        msg_wait = 0;
      end
      if (upd_en) begin
        obs_upd_cnt++;
        obs_upd_idx = upd_index;
        obs_upd_way = upd_way;
        obs_upd_state = upd_state;
      end
      if (proto_err) obs_err_cnt++;
      if (rsp_valid) begin
        if (!rsp_hold) begin
          obs_lat = n;
          obs_res = rsp_result;
          rsp_hold = 1'b1;
        end else if (rsp_result !== obs_res) begin
          obs_unstable++;
        end
        rsp_wait++;
        rsp_ready = (rsp_wait > rsp_dly);
        if (rsp_ready) done = 1'b1;
      end else begin
        rsp_ready = 1'b0;
      end
      // A held request while busy carries garbage that must never be taken.
      snp_valid = hold_valid && !rsp_hold;
      snp_op    = 3'($urandom);
      snp_addr  = $urandom;
    end
    @(negedge clk);
    rsp_ready = 1'b0; lkp_ack = 1'b0; l1_msg_ready = 1'b0; snp_valid = 1'b0;
    if (obs_timeout != 0) begin
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
    end else begin
      obs_idle_after = int'(snp_ready && !rsp_valid);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (snp_ready !== 1'b0) begin
      errors++; $display("FAIL reset_ready_low: got %b want 0", snp_ready);
    end
    checks++;
    if (side_outs !== '0) begin
      errors++; $display("FAIL reset_outputs: got %h want 0", side_outs);
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (snp_ready !== 1'b1 || side_outs !== '0) begin
      errors++; $display("FAIL reset_release: ready %b outs %h want ready 1 outs 0", snp_ready,
                         side_outs);
    end
  endtask

  task automatic test_read_m();
    do_snoop(READ, 32'h1234_5678, 1'b1, 3'd5, MESI_M, 0, 0, 0, 1'b0);
    checks++;
    if (obs_timeout != 0) begin errors++; $display("FAIL read_m_timeout: got 1 want 0"); end
    checks++;
    if (obs_idx !== 15'h5159 || obs_tag !== 11'h091) begin
      errors++; $display("FAIL read_m_lookup: got idx %h tag %h want 5159 091", obs_idx, obs_tag);
    end
    checks++;
    if (obs_msgs.size() != 1 || obs_msgs[0] !== GETLINE || obs_addr_bad != 0) begin
      errors++; $display("FAIL read_m_msgs: got %0d msgs, bad addr %0d want 1 GETLINE at 12345640",
                         obs_msgs.size(), obs_addr_bad);
    end
    checks++;
    if (obs_upd_cnt != 1 || obs_upd_way !== 3'd5 || obs_upd_state !== MESI_S ||
        obs_upd_idx !== 15'h5159) begin
      errors++; $display("FAIL read_m_update: got cnt %0d way %0d st %0d idx %h want 1 5 2 5159",
                         obs_upd_cnt, obs_upd_way, obs_upd_state, obs_upd_idx);
    end
    checks++;
    if (obs_res !== HITM || obs_lat != 4) begin
      errors++; $display("FAIL read_m_rsp: got res %0d lat %0d want 2 4", obs_res, obs_lat);
    end
  endtask

  task automatic test_rwim_e();
    do_snoop(RWIM, 32'h1234_5678, 1'b1, 3'd3, MESI_E, 0, 0, 0, 1'b0);
    checks++;
    if (obs_msgs.size() != 1 || obs_msgs[0] !== INVALIDATELINE) begin
      errors++; $display("FAIL rwim_e_msgs: got %0d msgs want 1 INVALIDATELINE", obs_msgs.size());
    end
    checks++;
    if (obs_upd_cnt != 1 || obs_upd_state !== MESI_I || obs_upd_way !== 3'd3) begin
      errors++; $display("FAIL rwim_e_update: got cnt %0d st %0d way %0d want 1 3 3", obs_upd_cnt,
                         obs_upd_state, obs_upd_way);
    end
    checks++;
    if (obs_res !== HIT || obs_lat != 4) begin
      errors++; $display("FAIL rwim_e_rsp: got res %0d lat %0d want 1 4", obs_res, obs_lat);
    end
  endtask

  task automatic test_read_miss();
    for (int k = 0; k < 2; k++) begin
      do_snoop(READ, 32'h0F0F_0F00, (k == 1), 3'd6, (k == 1) ? MESI_I : MESI_M, 0, 0, 0, 1'b0);
      checks++;
      if (obs_msgs.size() != 0 || obs_upd_cnt != 0 || obs_err_cnt != 0) begin
        errors++; $display("FAIL read_miss_side_effects[%0d]: got msgs %0d upd %0d err %0d want 0",
                           k, obs_msgs.size(), obs_upd_cnt, obs_err_cnt);
      end
      checks++;
      if (obs_res !== NOHIT || obs_lat != 3) begin
        errors++; $display("FAIL read_miss_rsp[%0d]: got res %0d lat %0d want 0 3", k, obs_res,
                           obs_lat);
      end
    end
  endtask

  task automatic test_inval_m();
    do_snoop(INVALIDATE, 32'hCAFE_0080, 1'b1, 3'd1, MESI_M, 0, 0, 0, 1'b0);
    checks++;
    if (obs_err_cnt != 1 || obs_upd_cnt != 0 || obs_msgs.size() != 0) begin
      errors++; $display("FAIL inval_m_err: got err %0d upd %0d msgs %0d want 1 0 0", obs_err_cnt,
                         obs_upd_cnt, obs_msgs.size());
    end
    checks++;
    if (obs_res !== NOHIT || obs_lat != 3) begin
      errors++; $display("FAIL inval_m_rsp: got res %0d lat %0d want 0 3", obs_res, obs_lat);
    end
  endtask

  task automatic test_stalls();
    do_snoop(READ, 32'h1234_5678, 1'b1, 3'd5, MESI_M, 3, 2, 4, 1'b1);
    checks++;
    if (obs_unstable != 0 || obs_ready_busy != 0) begin
      errors++; $display("FAIL stall_read_hold: got unstable %0d ready_busy %0d want 0 0",
                         obs_unstable, obs_ready_busy);
    end
    checks++;
    if (obs_lat != 9 || obs_res !== HITM || obs_msgs.size() != 1 || obs_upd_cnt != 1) begin
      errors++; $display("FAIL stall_read_flow: got lat %0d res %0d msgs %0d upd %0d want 9 2 1 1",
                         obs_lat, obs_res, obs_msgs.size(), obs_upd_cnt);
    end
    checks++;
    if (obs_idle_after != 1) begin
      errors++; $display("FAIL stall_read_idle: got %0d want 1", obs_idle_after);
    end
    do_snoop(RWIM, 32'h89AB_CDEF, 1'b1, 3'd7, MESI_M, 3, 2, 4, 1'b1);
    checks++;
    if (obs_msgs.size() != 2 || obs_msgs[0] !== GETLINE || obs_msgs[1] !== INVALIDATELINE) begin
      errors++; $display("FAIL stall_rwim_msgs: got %0d msgs want GETLINE then INVALIDATELINE",
                         obs_msgs.size());
    end
    checks++;
    if (obs_lat != 12 || obs_res !== HITM || obs_unstable != 0 || obs_ready_busy != 0) begin
      errors++; $display("FAIL stall_rwim_flow: got lat %0d res %0d unst %0d rb %0d want 12 2 0 0",
                         obs_lat, obs_res, obs_unstable, obs_ready_busy);
    end
  endtask

  task automatic test_random_back_to_back();
    logic [2:0]    op, res, m0;
    logic [AW-1:0] addr;
    logic          hit;
    logic [WB-1:0] way;
    logic [1:0]    st, nxt;
    int            ad, ld, rd, nmsg, lat;
    bit            err, hold, upd;
    for (int i = 0; i < 60; i++) begin
      op = 3'($urandom); addr = $urandom; hit = 1'($urandom); way = WB'($urandom);
      st = 2'($urandom); ad = $urandom_range(0, 2); ld = $urandom_range(0, 2);
      rd = $urandom_range(0, 2); hold = 1'($urandom);
      ref_model(op, hit, st, res, nmsg, m0, nxt, err);
      upd = hit && (st != MESI_I) && (nxt != st);
      lat = 3 + ad + nmsg * (1 + ld);
      do_snoop(op, addr, hit, way, st, ad, ld, rd, hold);
      checks++;
      if (obs_res !== res || obs_lat != lat || obs_timeout != 0) begin
        errors++; $display("FAIL rand_rsp[%0d]: op %0d got res %0d lat %0d want %0d %0d", i, op,
                           obs_res, obs_lat, res, lat);
      end
      checks++;
      if (obs_idx !== addr[BB +: IB] || obs_tag !== addr[AW-1 -: TB]) begin
        errors++; $display("FAIL rand_lookup[%0d]: got %h/%h want %h/%h", i, obs_idx, obs_tag,
                           addr[BB +: IB], addr[AW-1 -: TB]);
      end
      checks++;
      if (obs_msgs.size() != nmsg || (nmsg > 0 && obs_msgs[0] !== m0) || obs_addr_bad != 0) begin
        errors++; $display("FAIL rand_msgs[%0d]: op %0d got %0d msgs want %0d first %0d", i, op,
                           obs_msgs.size(), nmsg, m0);
      end
      checks++;
      if (obs_upd_cnt != int'(upd) || obs_err_cnt != int'(err)) begin
        errors++; $display("FAIL rand_upd_err[%0d]: got upd %0d err %0d want %0d %0d", i,
                           obs_upd_cnt, obs_err_cnt, upd, err);
      end
      if (upd) begin
        checks++;
        if (obs_upd_state !== nxt || obs_upd_way !== way || obs_upd_idx !== addr[BB +: IB]) begin
          errors++; $display("FAIL rand_upd_fields[%0d]: got st %0d way %0d want %0d %0d", i,
                             obs_upd_state, obs_upd_way, nxt, way);
        end
      end
      checks++;
      if (obs_unstable != 0 || obs_ready_busy != 0 || obs_idle_after != 1) begin
        errors++; $display("FAIL rand_handshake[%0d]: got unst %0d rb %0d idle %0d want 0 0 1", i,
                           obs_unstable, obs_ready_busy, obs_idle_after);
      end
    end
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    snp_valid = 1'b1; snp_op = READ; snp_addr = 32'h0ABC_DE40;
    @(negedge clk);
    snp_valid = 1'b0; lkp_ack = 1'b1; lkp_hit = 1'b1; lkp_way = 3'd2; lkp_state = MESI_M;
    @(negedge clk);
    lkp_ack = 1'b0; l1_msg_ready = 1'b0;
    checks++;
    if (l1_msg_valid !== 1'b1) begin
      errors++; $display("FAIL rstmid_in_getl: got l1_msg_valid %b want 1", l1_msg_valid);
    end
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if ({snp_ready, side_outs} !== '0) begin
      errors++; $display("FAIL rstmid_quiet: got %h want 0", {snp_ready, side_outs});
    end
    rst = 1'b0;
    @(negedge clk);
    checks++;
    if (snp_ready !== 1'b1 || side_outs !== '0) begin
      errors++; $display("FAIL rstmid_idle: got ready %b outs %h want 1 0", snp_ready, side_outs);
    end
    do_snoop(RWIM, 32'h0ABC_DE40, 1'b1, 3'd1, MESI_S, 0, 0, 0, 1'b0);
    checks++;
    if (obs_res !== HIT || obs_lat != 4 || obs_msgs.size() != 1 || obs_upd_state !== MESI_I) begin
      errors++; $display("FAIL rstmid_next: got res %0d lat %0d msgs %0d st %0d want 1 4 1 3",
                         obs_res, obs_lat, obs_msgs.size(), obs_upd_state);
    end
  endtask

  initial begin
    rst = 1'b1; snp_valid = 1'b0; snp_op = '0; snp_addr = '0;
    lkp_ack = 1'b0; lkp_hit = 1'b0; lkp_way = '0; lkp_state = '0;
    l1_msg_ready = 1'b0; rsp_ready = 1'b0;
    test_reset();
    test_read_m();
    test_rwim_e();
    test_read_miss();
    test_inval_m();
    test_stalls();
    test_random_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
